alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue stage directly upstream of alu: decodes RV32I OP, OP-IMM, LUI, AUIPC instructions.
//  Selects operands from register data, immediate or PC, and maps funct3/funct7 to the 4-bit ALU operation code.
//  Holds the decoded micro-op in a 2-entry skid buffer with valid/ready on both sides.
//  Outputs drive alu operand1/operand2/operation directly.
// PARAMETERS
//  XLEN        32   datapath width; only 32 is supported
//  PC_RESET    0    value driven on out_pc during reset
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  flush        in   1     synchronous: discard all buffered entries
//  in_valid     in   1     instruction/operands valid
//  in_ready     out  1     stage can accept; registered
//  in_instr     in   32    RV32I instruction word
//  in_pc        in   XLEN  instruction address
//  in_rs1_data  in   XLEN  rs1 register value
//  in_rs2_data  in   XLEN  rs2 register value
//  out_valid    out  1     decoded micro-op valid
//  out_ready    in   1     consumer accepts micro-op
//  out_operand1 out  XLEN  to alu.operand1
//  out_operand2 out  XLEN  to alu.operand2
//  out_operation out 4     to alu.operation
//  out_rd       out  5     destination register; 0 means no write
//  out_illegal  out  1     instruction not decodable by this stage
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, out_operand1/2=0, out_operation=0, out_rd=0, out_illegal=0, state EMPTY.
//  Opcode encodings:
//   OP=0110011, OP-IMM=0010011, LUI=0110111, AUIPC=0010111; any other opcode sets illegal=1.
//  Op codes: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASS_B=A.
//  Operation and operand mapping:
//   OP/OP-IMM: operation from funct3. funct7=0100000 selects SUB (OP only) or SRA/SRAI.
//   Any other funct7 not 0000000 on OP, SLLI, SRLI or SRAI sets illegal.
//   operand1=rs1_data. operand2=rs2_data (OP) or sign-extended I-immediate (OP-IMM).
//   For shift-immediates, operand2 is the zero-extended shamt.
//   LUI: operand1=0, operand2={imm[31:12],12'b0}, operation=PASS_B.
//   AUIPC: operand1=pc, operand2=U-immediate, operation=ADD.
//  Illegal entry: still transferred, with illegal=1, operation=ADD, operand1=0, operand2=0, rd=0.
//  Handshake: a transfer occurs when valid&&ready. Producer holds data stable while valid&&!ready.
//  out_valid never drops without out_ready.
//  Latency: accept in cycle N -> out_valid in N+1 when buffer EMPTY. No combinational in->out path.
//  Skid FSM:
//   EMPTY -(accept)-> ONE.
//   ONE -(accept & !out_ready)-> FULL.
//   ONE -(out_ready & !accept)-> EMPTY.
//   ONE -(both)-> ONE; main register loaded with the new entry.
//   FULL -(out_ready)-> ONE; skid entry moves to main.
//   in_ready=(state!=FULL), registered.
//  Flush: next state EMPTY; same-cycle input is discarded; beats out_ready and accept.
//  Reset mid-transfer: all entries lost; outputs return to reset values immediately (async).
//  Ordering: strict FIFO; at most 2 entries buffered.
// CONFIGURATION
//  ALU_ISSUE_FWD_EN defined:
//   Adds ports fwd_valid(in,1), fwd_rd(in,5), fwd_data(in,XLEN).
//   On accept, if fwd_valid && fwd_rd!=0 && fwd_rd==rs1 (or rs2), fwd_data replaces in_rs1_data (resp. in_rs2_data).
//   Forwarding applies only to the operands the instruction actually uses.
//  ALU_ISSUE_FWD_EN undefined: ports absent; register data used verbatim.
// STRUCTURE
//  Package alu_pkg:
//   alu_op_t (4-bit enum above), opcode localparams, micro-op struct {operand1, operand2, op, rd, illegal}.
//   Shared with alu and its benches.
//  Sub-module alu_issue_decode: purely combinational instr -> micro-op.
//  The top level holds the skid FSM and registers.
// TESTING
//  1 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle op=0, operand1=5, operand2=7, rd=3.
//  2 sub (0x402081B3), rs1=5, rs2=7 -> op=1; alu result 0xFFFFFFFE.
//  3 addi x1,x0,-1 (0xFFF00093) -> operand2=0xFFFFFFFF, op=0. srai x1,x1,4 (0x4040D093) -> op=7, operand2=4.
//  4 lui x5,0x12345 (0x123452B7) -> op=A, operand2=0x12345000, rd=5.
//    Instr 0xFFFFFFFF -> illegal=1, rd=0.
//  5 out_ready=0 while 3 instrs are offered:
//    2 are accepted, then in_ready=0. Release -> all 3 emerge in order, none lost or duplicated.
//  6 flush while FULL -> out_valid=0 and in_ready=1 next cycle.
//    rst_n pulse mid-stream -> outputs 0 asynchronously.
//    FWD_EN: fwd_rd=1, fwd_data=9 -> operand1=9.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU issue stage, the ALU and
// their benches.
//   alu_op_t       4-bit ALU operation code
//   OPC_*          RV32I major opcodes decoded by the issue stage
//   uop_t          decoded micro-op {operand1, operand2, op, rd, illegal}
//   funct3_to_op   maps funct3 plus the funct7 "alternate" bit to alu_op_t
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_SLL    = 4'h2,
    ALU_SLT    = 4'h3,
    ALU_SLTU   = 4'h4,
    ALU_XOR    = 4'h5,
    ALU_SRL    = 4'h6,
    ALU_SRA    = 4'h7,
    ALU_OR     = 4'h8,
    ALU_AND    = 4'h9,
    ALU_PASS_B = 4'hA
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] operand1;
    logic [31:0] operand2;
    alu_op_t     op;
    logic [4:0]  rd;
    logic        illegal;
  } uop_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_op_t funct3_to_op(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational RV32I OP / OP-IMM / LUI / AUIPC
// decoder producing one ALU micro-op.
//   instr     in   32  instruction word
//   pc        in   32  instruction address (AUIPC operand1)
//   rs1_data  in   32  rs1 value (already forwarded if applicable)
//   rs2_data  in   32  rs2 value (already forwarded if applicable)
//   uop       out      decoded micro-op; illegal entries are zeroed with op=ADD
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output uop_t        uop
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    uop   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        // The alternate funct7 is only meaningful for SUB and SRA.
        legal = (funct7 == F7_ZERO) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        uop.op       = funct3_to_op(funct3, funct7 == F7_ALT);
        uop.operand1 = rs1_data;
        uop.operand2 = rs2_data;
        uop.rd       = instr[11:7];
      end
      OPC_OP_IMM: begin
        uop.operand1 = rs1_data;
        uop.rd       = instr[11:7];
        if (funct3 == 3'b001) begin
          legal        = (funct7 == F7_ZERO);
          uop.operand2 = {27'd0, instr[24:20]};
        end else if (funct3 == 3'b101) begin
          legal        = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          uop.operand2 = {27'd0, instr[24:20]};
        end else begin
          legal        = 1'b1;
          uop.operand2 = {{20{instr[31]}}, instr[31:20]};
        end
        // For ADDI, instr[30] is immediate data, not a SUB selector.
        uop.op = funct3_to_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
      end
      OPC_LUI: begin
        legal        = 1'b1;
        uop.operand1 = '0;
        uop.operand2 = {instr[31:12], 12'd0};
        uop.op       = ALU_PASS_B;
        uop.rd       = instr[11:7];
      end
      OPC_AUIPC: begin
        legal        = 1'b1;
        uop.operand1 = pc;
        uop.operand2 = {instr[31:12], 12'd0};
        uop.op       = ALU_ADD;
        uop.rd       = instr[11:7];
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      uop         = '0;
      uop.op      = ALU_ADD;
      uop.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage in front of the ALU. Decodes RV32I
// OP, OP-IMM, LUI, AUIPC and buffers the micro-op in a 2-entry skid buffer.
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous discard of all buffered entries
//   in_valid/ready   upstream handshake (in_ready is registered)
//   in_instr/pc/rs1_data/rs2_data   instruction and register operands
//   out_valid/ready  downstream handshake
//   out_operand1/2, out_operation   drive alu directly
//   out_rd, out_illegal, out_pc     destination, illegal flag, instr address
// Optional feature, macro ALU_ISSUE_FWD_EN: adds fwd_valid/fwd_rd/fwd_data
// and substitutes fwd_data for a matching rs1/rs2 at accept time.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand1,
  output logic [XLEN-1:0] out_operand2,
  output logic [3:0]      out_operation,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  uop_t            main_q, main_d, skid_q, skid_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;

  logic [XLEN-1:0] rs1_val, rs2_val;
  uop_t            dec_uop;
  logic            accept, pop;

`ifdef ALU_ISSUE_FWD_EN
  // Unused operands are also replaced here, but the decoder never routes
  // them to the ALU, so only the operands an instruction uses are affected.
  assign rs1_val = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_instr[19:15]))
                   ? fwd_data : in_rs1_data;
  assign rs2_val = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == in_instr[24:20]))
                   ? fwd_data : in_rs2_data;
`else
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;
`endif

  alu_issue_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .uop      (dec_uop)
  );

  assign accept = in_valid && in_ready_q;
  assign pop    = (state_q != S_EMPTY) && out_ready;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    main_pc_d = main_pc_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d   = S_ONE;
            main_d    = dec_uop;
            main_pc_d = in_pc;
          end
        end
        S_ONE: begin
          if (accept && !pop) begin
            state_d   = S_FULL;
            skid_d    = dec_uop;
            skid_pc_d = in_pc;
          end else if (accept && pop) begin
            main_d    = dec_uop;
            main_pc_d = in_pc;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so no accept can coincide with the pop.
          if (pop) begin
            state_d   = S_ONE;
            main_d    = skid_q;
            main_pc_d = skid_pc_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d = (state_d != S_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      main_pc_q  <= PC_RESET;
      skid_pc_q  <= PC_RESET;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_pc_q  <= main_pc_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != S_EMPTY);
  assign out_operand1  = main_q.operand1;
  assign out_operand2  = main_q.operand2;
  assign out_operation = main_q.op;
  assign out_rd        = main_q.rd;
  assign out_illegal   = main_q.illegal;
  assign out_pc        = main_pc_q;

endmodule
